// File: rtl/klp32_mmio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | klp32_mmio_pkg                                                        |
// | Shared register map, bit positions and UART TX state type.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package klp32_mmio_pkg;

  // Word offsets decoded from bus_addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_fifo                                                             |
// | Single-clock first-word-fall-through FIFO; push allowed when full if  |
// | a pop happens in the same cycle.                                      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mmio_uart_tx                                                          |
// | MMIO 8N1 UART transmitter with TX FIFO, status/baud/ctrl registers    |
// | and a registered level interrupt.                                     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mmio_uart_tx
  import klp32_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_data,
  output logic [31:0] bus_rd_data,
  input  logic        bus_cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t r_state;
  uart_tx_state_t w_state_nxt;
  logic [15:0]    r_baud;
  logic [15:0]    r_div_lat;
  logic [15:0]    r_timer;
  logic [7:0]     r_shift;
  logic [2:0]     r_bitcnt;
  logic           r_enable;
  logic           r_irq_en;
  logic           r_overrun;
  logic           r_irq;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_wr;
  logic           w_wr_txdata;
  logic           w_bit_end;
  logic           w_busy;
  logic [7:0]     w_fifo_data;
  logic [CW-1:0]  w_count;
  logic [7:0]     w_count8;
  logic           w_unused;

  assign w_wr        = bus_cs & bus_wr;
  assign w_wr_txdata = w_wr & (bus_addr[3:2] == REG_TXDATA);
  assign w_busy      = (r_state != IDLE);
  assign w_pop       = (r_state == IDLE) & r_enable & ~w_empty;
  assign w_bit_end   = (r_timer == '0);
  assign w_count8    = 8'(w_count);
  assign irq         = r_irq;
  assign w_unused    = ^{bus_addr[31:4], bus_addr[1:0], bus_wr_data[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_in),
    .i_push  (w_wr_txdata),
    .i_data  (bus_wr_data[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_baud    <= 16'(DEFAULT_DIV);
      r_enable  <= 1'b1;
      r_irq_en  <= 1'b0;
      r_overrun <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr) begin
        case (bus_addr[3:2])
          REG_STATUS:  if (bus_wr_data[STAT_OVERRUN]) r_overrun <= 1'b0;
          REG_BAUDDIV: r_baud <= bus_wr_data[15:0];
          REG_CTRL: begin
            r_enable <= bus_wr_data[CTRL_ENABLE];
            r_irq_en <= bus_wr_data[CTRL_IRQ_EN];
          end
          default: ;
        endcase
      end
      if (w_wr_txdata && w_full && !w_pop) r_overrun <= 1'b1;
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_nxt = START;
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && (r_bitcnt == 3'd7)) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The divisor is latched per frame so BAUDDIV writes only affect the next frame.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_timer   <= '0;
      r_div_lat <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
    end else if (w_pop) begin
      r_shift   <= w_fifo_data;
      r_timer   <= r_baud;
      r_div_lat <= r_baud;
      r_bitcnt  <= '0;
    end else if (r_state != IDLE) begin
      if (w_bit_end) begin
        r_timer <= r_div_lat;
        if (r_state == DATA) begin
          r_shift  <= {1'b0, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
      end else begin
        r_timer <= r_timer - 16'd1;
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    bus_rd_data = '0;
    if (bus_cs && bus_rd) begin
      case (bus_addr[3:2])
        REG_STATUS: begin
          bus_rd_data[STAT_BUSY]                = w_busy;
          bus_rd_data[STAT_FULL]                = w_full;
          bus_rd_data[STAT_EMPTY]               = w_empty;
          bus_rd_data[STAT_OVERRUN]             = r_overrun;
          bus_rd_data[STAT_COUNT_LSB +: 8]      = w_count8;
        end
        REG_BAUDDIV: bus_rd_data[15:0] = r_baud;
        REG_CTRL: begin
          bus_rd_data[CTRL_ENABLE] = r_enable;
          bus_rd_data[CTRL_IRQ_EN] = r_irq_en;
        end
        default: bus_rd_data = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mmio_uart_tx                                                       |
// | Register vector table plus serial-frame scoreboard for mmio_uart_tx.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_cs;
  logic        bus_wr;
  logic        bus_rd;
  logic        tx;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tb_p = 4;
  int frames_done = 0;
  logic mon_en = 1'b0;
  logic prev_tx = 1'b1;
  logic [7:0] sb[$];
  int starts[$];

  typedef struct {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(433)) dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_cs      (bus_cs),
    .bus_wr      (bus_wr),
    .bus_rd      (bus_rd),
    .tx          (tx),
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  function automatic vec_t mk(input logic cs, input logic wr, input logic rd,
                              input logic [3:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp);
    vec_t v;
    v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wd; v.exp = exp;
    return v;
  endfunction

  task automatic bus_idle();
    bus_cs = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    bus_addr = '0; bus_wr_data = '0;
  endtask

  task automatic drive_wr(input logic [3:0] addr, input logic [31:0] data);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_rd = 1'b0;
    bus_addr = {28'h0, addr}; bus_wr_data = data;
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    drive_wr(addr, data);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd_now(input logic [3:0] addr, output logic [31:0] data);
    bus_cs = 1'b1; bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = {28'h0, addr};
    #1;
    data = bus_rd_data;
    bus_idle();
  endtask

  task automatic wait_drained(input string name);
    logic [31:0] d;
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      rd_now(4'h4, d);
      if (sb.size() == 0 && d[0] == 1'b0) break;
    end
    if (t == 3000) timeout(name);
  endtask

  // Frame monitor: every bit must hold for exactly tb_p cycles.
  always begin : mon
    int p;
    logic [9:0] bits;
    logic stable;
    logic [7:0] exp;
    @(negedge clk);
    if (mon_en && reset_in && tx === 1'b0 && prev_tx === 1'b1) begin
      p = tb_p;
      bits = '0;
      stable = 1'b1;
      starts.push_back(cyc);
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < p; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (k == 0) bits[b] = tx;
          else if (tx !== bits[b]) stable = 1'b0;
        end
      end
      if (sb.size() == 0) begin
        timeout("frame_unexpected");
      end else begin
        exp = sb.pop_front();
        chk("frame_byte", {24'h0, bits[8:1]}, {24'h0, exp});
      end
      chk("frame_format", {29'h0, stable, bits[9], bits[0]}, 32'h6);
      frames_done++;
    end
    prev_tx = tx;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int fd0;
    int t;
    bus_idle();
    reset_in = 1'b0;

    vecs[0]  = mk(1, 0, 1, 4'h4, 32'h0,         32'h0000_0004);
    vecs[1]  = mk(1, 0, 1, 4'h8, 32'h0,         32'd433);
    vecs[2]  = mk(1, 0, 1, 4'hC, 32'h0,         32'h1);
    vecs[3]  = mk(1, 0, 1, 4'h0, 32'h0,         32'h0);
    vecs[4]  = mk(0, 0, 1, 4'h4, 32'h0,         32'h0);
    vecs[5]  = mk(1, 0, 0, 4'h4, 32'h0,         32'h0);
    vecs[6]  = mk(0, 1, 0, 4'h0, 32'h77,        32'h0);
    vecs[7]  = mk(1, 0, 1, 4'h4, 32'h0,         32'h0000_0004);
    vecs[8]  = mk(1, 1, 0, 4'h8, 32'hABCD_1234, 32'h0);
    vecs[9]  = mk(1, 0, 1, 4'h8, 32'h0,         32'h0000_1234);
    vecs[10] = mk(1, 1, 0, 4'hC, 32'hFFFF_FFFC, 32'h0);
    vecs[11] = mk(1, 0, 1, 4'hC, 32'h0,         32'h0);
    vecs[12] = mk(1, 1, 0, 4'hC, 32'h1,         32'h0);
    vecs[13] = mk(1, 0, 1, 4'hC, 32'h0,         32'h1);
    vecs[14] = mk(1, 1, 0, 4'h4, 32'hFFFF_FFF7, 32'h0);
    vecs[15] = mk(1, 0, 1, 4'h4, 32'h0,         32'h0000_0004);

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_tx_held", {31'h0, tx}, 32'h1);
    chk("rst_irq_held", {31'h0, irq}, 32'h0);
    reset_in = 1'b1;
    @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    mon_en = 1'b1;

    // Register / bus-gating table
    for (int i = 0; i < 16; i++) begin
      bus_cs = vecs[i].cs; bus_wr = vecs[i].wr; bus_rd = vecs[i].rd;
      bus_addr = {28'h0, vecs[i].addr}; bus_wr_data = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rd_data", i), bus_rd_data, vecs[i].exp);
      @(negedge clk);
      bus_idle();
    end

    // Single frame, with a mid-frame BAUDDIV write that must not disturb it
    bus_write(4'h8, 32'd3);
    tb_p = 4;
    sb.push_back(8'h55);
    bus_write(4'h0, 32'h55);
    chk("t2_tx_n1", {31'h0, tx}, 32'h1);
    @(negedge clk);
    chk("t2_tx_fall_n2", {31'h0, tx}, 32'h0);
    repeat (8) @(negedge clk);
    bus_write(4'h8, 32'd1);
    repeat (30) @(negedge clk);
    rd_now(4'h4, d);
    chk("t2_busy_n41", {31'h0, d[0]}, 32'h1);
    @(negedge clk);
    rd_now(4'h4, d);
    chk("t2_busy_n42", {31'h0, d[0]}, 32'h0);
    tb_p = 2;

    // Overrun with transmitter disabled; ninth byte is dropped
    bus_write(4'hC, 32'h0);
    for (int i = 0; i < 9; i++) begin
      drive_wr(4'h0, 32'h10 + 32'(i * 17));
      if (i < 8) sb.push_back(8'(8'h10 + i * 17));
      @(negedge clk);
    end
    bus_idle();
    rd_now(4'h4, d);
    chk("t3_status_full_ovr", d, 32'h0000_080A);
    bus_write(4'h4, 32'h8);
    rd_now(4'h4, d);
    chk("t3_status_ovr_clr", d, 32'h0000_0802);
    bus_write(4'hC, 32'h1);
    wait_drained("t3_drain");

    // Back-to-back frames and interrupt
    bus_write(4'hC, 32'h3);
    chk("t4_irq_lag", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("t4_irq_idle", {31'h0, irq}, 32'h1);
    starts.delete();
    fd0 = frames_done;
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    drive_wr(4'h0, 32'hA5);
    @(negedge clk);
    drive_wr(4'h0, 32'h3C);
    @(negedge clk);
    bus_idle();
    chk("t4_irq_low", {31'h0, irq}, 32'h0);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (frames_done >= fd0 + 2) break;
    end
    if (t == 200) timeout("t4_frames");
    chk("t4_nframes", 32'(starts.size()), 32'd2);
    if (starts.size() >= 2) chk("t4_start_spacing", 32'(starts[1] - starts[0]), 32'd21);
    repeat (3) @(negedge clk);
    chk("t4_irq_after", {31'h0, irq}, 32'h1);
    bus_write(4'hC, 32'h1);

    // Reset in the middle of a data bit with bytes queued
    mon_en = 1'b0;
    bus_write(4'h8, 32'd3);
    drive_wr(4'h0, 32'h00); @(negedge clk);
    drive_wr(4'h0, 32'h11); @(negedge clk);
    drive_wr(4'h0, 32'h22); @(negedge clk);
    drive_wr(4'h0, 32'h33); @(negedge clk);
    bus_idle();
    repeat (4) @(negedge clk);
    chk("t5_tx_data0", {31'h0, tx}, 32'h0);
    rd_now(4'h4, d);
    chk("t5_status_pre", d, 32'h0000_0301);
    reset_in = 1'b0;
    #1;
    chk("t5_tx_async", {31'h0, tx}, 32'h1);
    @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    rd_now(4'h4, d);
    chk("t5_status_post", d, 32'h0000_0004);
    rd_now(4'h8, d);
    chk("t5_baud_post", d, 32'd433);
    mon_en = 1'b1;

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
